// File: rtl/prog_loader_if.sv
// Stream handshake carrying program words into the loader.
// The source drives the master modport; the loader consumes the slave modport.
interface prog_loader_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader. It sits in front of the CPU program RAM, writes a
// streamed program from address 0 upward, and holds the CPU in reset until the
// load has finished.
// Optional feature: define PROG_LOADER_CHECKSUM_EN to get a running 16-bit
// modular sum of the written words on o_checksum. When it is undefined the
// port is tied to 0.
module prog_loader #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int LOAD_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  prog_loader_if.slave      in_bus,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_d,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_word_count,
  output logic              o_err_overflow,
  output logic [DATA_W-1:0] o_checksum
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Count value that marks the final word slot of a load.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(LOAD_DEPTH - 1);

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_count;
  logic              r_err;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_d;
  logic              r_done;
  logic              r_hold;

  logic w_in_load;
  logic w_ready;
  logic w_beat;
  logic w_write;
  logic w_full;

  // The write pointer is the word count itself, so no separate pointer register
  // is kept. Overflow is detected while the final slot is being filled, so the
  // count never needs to pass LOAD_DEPTH.
  assign w_in_load = (r_state == ST_LOAD);
  assign w_ready   = w_in_load || (r_state == ST_DRAIN);
  assign w_beat    = in_bus.in_valid && w_ready;
  assign w_write   = w_beat && w_in_load;
  assign w_full    = (r_count == LAST_IDX);

  assign in_bus.in_ready = w_ready;
  assign o_busy          = w_ready;
  assign o_mem_we        = r_we;
  assign o_mem_addr      = r_addr;
  assign o_mem_d         = r_d;
  assign o_done          = r_done;
  assign o_cpu_hold      = r_hold;
  assign o_word_count    = r_count;
  assign o_err_overflow  = r_err;

  // Load sequencing: state, word count and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state <= ST_LOAD;
            r_count <= '0;
            r_err   <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_beat) begin
            r_count <= r_count + 1'b1;
            if (in_bus.in_last) begin
              r_state <= ST_DONE;
            end else if (w_full) begin
              r_state <= ST_DRAIN;
              r_err   <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_beat && in_bus.in_last) begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM write port: each accepted word is written one cycle after its beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_d    <= '0;
    end else begin
      r_we <= w_write;
      if (w_write) begin
        r_addr <= r_count[ADDR_W-1:0];
        r_d    <= in_bus.in_data;
      end
    end
  end

  // CPU release: done/hold change one cycle after entering DONE, so the CPU
  // leaves reset only after the final RAM write has landed. A start in DONE
  // re-holds the CPU on the very next cycle, before any new write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
      r_hold <= 1'b1;
    end else begin
      r_done <= (r_state == ST_DONE) && !i_start;
      r_hold <= !((r_state == ST_DONE) && !i_start);
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;

  // Running modular sum of written words; discarded DRAIN words are excluded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum <= '0;
    end else if (i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE))) begin
      r_sum <= '0;
    end else if (w_write) begin
      r_sum <= r_sum + in_bus.in_data;
    end
  end

  assign o_checksum = r_sum;
`else
  assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader, built with LOAD_DEPTH=4 so the
// overflow and last-on-full boundaries are reachable with short streams.
module tb_prog_loader;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memD;
  logic              cpuHold;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wordCount;
  logic              errOverflow;
  logic [DATA_W-1:0] checksum;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] logAddr [16];
  logic [DATA_W-1:0] logData [16];
  int                logN;

  prog_loader_if #(.DATA_W(DATA_W)) inBus ();

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOAD_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (start),
    .in_bus         (inBus.slave),
    .o_mem_we       (memWe),
    .o_mem_addr     (memAddr),
    .o_mem_d        (memD),
    .o_cpu_hold     (cpuHold),
    .o_busy         (busy),
    .o_done         (done),
    .o_word_count   (wordCount),
    .o_err_overflow (errOverflow),
    .o_checksum     (checksum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] expSum(input logic [DATA_W-1:0] v);
`ifdef PROG_LOADER_CHECKSUM_EN
    return v;
`else
    return '0;
`endif
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one cycle of stream input, then record any RAM write seen after the edge.
  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic l);
    inBus.in_valid = v;
    inBus.in_data  = d;
    inBus.in_last  = l;
    tick();
    if (memWe === 1'b1 && logN < 16) begin
      logAddr[logN] = memAddr;
      logData[logN] = memD;
      logN++;
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    drive(1'b0, 16'h0000, 1'b0);
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (memWe !== 1'b0) begin errors++; $display("[TB] FAIL rst_we: got %b expected 0", memWe); end
    checks++; if (memAddr !== 8'h00) begin errors++; $display("[TB] FAIL rst_addr: got %h expected 00", memAddr); end
    checks++; if (memD !== 16'h0000) begin errors++; $display("[TB] FAIL rst_d: got %h expected 0000", memD); end
    checks++; if (cpuHold !== 1'b1) begin errors++; $display("[TB] FAIL rst_hold: got %b expected 1", cpuHold); end
    checks++; if (inBus.in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL rst_status: got ready=%b busy=%b done=%b expected 0 0 0", inBus.in_ready, busy, done); end
    checks++; if (wordCount !== 9'd0 || errOverflow !== 1'b0 || checksum !== 16'h0000) begin errors++; $display("[TB] FAIL rst_counts: got wc=%0d err=%b sum=%h expected 0 0 0000", wordCount, errOverflow, checksum); end
    rst = 1'b1;
    tick();
    // Abort a load after three beats with an asynchronous reset mid-cycle.
    pulseStart();
    drive(1'b1, 16'h0101, 1'b0);
    drive(1'b1, 16'h0202, 1'b0);
    drive(1'b1, 16'h0303, 1'b0);
    inBus.in_valid = 1'b0;
    checks++; if (memWe !== 1'b1) begin errors++; $display("[TB] FAIL t1_prewrite: got we=%b expected 1", memWe); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (memWe !== 1'b0) begin errors++; $display("[TB] FAIL t1_we: got %b expected 0", memWe); end
    checks++; if (cpuHold !== 1'b1) begin errors++; $display("[TB] FAIL t1_hold: got %b expected 1", cpuHold); end
    checks++; if (wordCount !== 9'd0) begin errors++; $display("[TB] FAIL t1_wc: got %0d expected 0", wordCount); end
    checks++; if (busy !== 1'b0 || inBus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL t1_idle: got busy=%b ready=%b expected 0 0", busy, inBus.in_ready); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || memWe !== 1'b0) begin errors++; $display("[TB] FAIL t1_after: got busy=%b done=%b we=%b expected 0 0 0", busy, done, memWe); end
  endtask

  task automatic test_basic();
    logN = 0;
    pulseStart();
    checks++; if (busy !== 1'b1 || inBus.in_ready !== 1'b1 || memWe !== 1'b0) begin errors++; $display("[TB] FAIL t2_load: got busy=%b ready=%b we=%b expected 1 1 0", busy, inBus.in_ready, memWe); end
    drive(1'b1, 16'h0001, 1'b0);
    checks++; if (logN !== 1) begin errors++; $display("[TB] FAIL t2_latency: got %0d writes expected 1", logN); end
    drive(1'b1, 16'h0203, 1'b0);
    drive(1'b1, 16'h0405, 1'b1);
    checks++; if (cpuHold !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL t2_lastwrite: got hold=%b done=%b expected 1 0", cpuHold, done); end
    idleCycles(1);
    checks++; if (done !== 1'b1 || cpuHold !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL t2_done: got done=%b hold=%b busy=%b expected 1 0 0", done, cpuHold, busy); end
    // Stream input in DONE must be ignored.
    drive(1'b1, 16'hDEAD, 1'b1);
    idleCycles(1);
    checks++; if (logN !== 3) begin errors++; $display("[TB] FAIL t2_nwrites: got %0d expected 3", logN); end
    checks++; if (logAddr[0] !== 8'd0 || logAddr[1] !== 8'd1 || logAddr[2] !== 8'd2) begin errors++; $display("[TB] FAIL t2_addr: got %0d %0d %0d expected 0 1 2", logAddr[0], logAddr[1], logAddr[2]); end
    checks++; if (logData[0] !== 16'h0001 || logData[1] !== 16'h0203 || logData[2] !== 16'h0405) begin errors++; $display("[TB] FAIL t2_data: got %h %h %h expected 0001 0203 0405", logData[0], logData[1], logData[2]); end
    checks++; if (wordCount !== 9'd3) begin errors++; $display("[TB] FAIL t2_wc: got %0d expected 3", wordCount); end
    checks++; if (checksum !== expSum(16'h0609)) begin errors++; $display("[TB] FAIL t2_sum: got %h expected %h", checksum, expSum(16'h0609)); end
  endtask

  task automatic test_gaps();
    logN = 0;
    pulseStart();
    checks++; if (cpuHold !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL t3_rehold: got hold=%b done=%b expected 1 0", cpuHold, done); end
    drive(1'b1, 16'hAAAA, 1'b0);
    // Idle beat with last set and a stray start: both must be ignored.
    start = 1'b1;
    drive(1'b0, 16'h1234, 1'b1);
    start = 1'b0;
    drive(1'b1, 16'h5555, 1'b1);
    idleCycles(2);
    checks++; if (logN !== 2) begin errors++; $display("[TB] FAIL t3_nwrites: got %0d expected 2", logN); end
    checks++; if (logAddr[0] !== 8'd0 || logAddr[1] !== 8'd1) begin errors++; $display("[TB] FAIL t3_addr: got %0d %0d expected 0 1", logAddr[0], logAddr[1]); end
    checks++; if (logData[0] !== 16'hAAAA || logData[1] !== 16'h5555) begin errors++; $display("[TB] FAIL t3_data: got %h %h expected AAAA 5555", logData[0], logData[1]); end
    checks++; if (wordCount !== 9'd2 || done !== 1'b1) begin errors++; $display("[TB] FAIL t3_end: got wc=%0d done=%b expected 2 1", wordCount, done); end
    checks++; if (checksum !== expSum(16'hFFFF)) begin errors++; $display("[TB] FAIL t3_sum: got %h expected %h", checksum, expSum(16'hFFFF)); end
  endtask

  task automatic test_overflow();
    logN = 0;
    pulseStart();
    for (int i = 0; i < 4; i++) drive(1'b1, 16'(16'h0010 + i), 1'b0);
    checks++; if (errOverflow !== 1'b1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL t4_drain: got err=%b busy=%b expected 1 1", errOverflow, busy); end
    drive(1'b1, 16'h0014, 1'b0);
    checks++; if (done !== 1'b0 || wordCount !== 9'd4) begin errors++; $display("[TB] FAIL t4_sat: got done=%b wc=%0d expected 0 4", done, wordCount); end
    drive(1'b1, 16'h0015, 1'b1);
    idleCycles(2);
    checks++; if (logN !== 4) begin errors++; $display("[TB] FAIL t4_nwrites: got %0d expected 4", logN); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (logAddr[i] !== 8'(i) || logData[i] !== 16'(16'h0010 + i)) begin errors++; $display("[TB] FAIL t4_write%0d: got addr=%0d data=%h expected %0d %h", i, logAddr[i], logData[i], i, 16'(16'h0010 + i)); end
    end
    checks++; if (errOverflow !== 1'b1 || wordCount !== 9'd4 || done !== 1'b1) begin errors++; $display("[TB] FAIL t4_end: got err=%b wc=%0d done=%b expected 1 4 1", errOverflow, wordCount, done); end
    checks++; if (checksum !== expSum(16'h0046)) begin errors++; $display("[TB] FAIL t4_sum: got %h expected %h", checksum, expSum(16'h0046)); end
  endtask

  task automatic test_last_on_full();
    logN = 0;
    pulseStart();
    checks++; if (errOverflow !== 1'b0) begin errors++; $display("[TB] FAIL t5_errclr: got %b expected 0", errOverflow); end
    for (int i = 0; i < 4; i++) drive(1'b1, 16'(16'h0020 + i), (i == 3));
    idleCycles(2);
    checks++; if (errOverflow !== 1'b0 || done !== 1'b1 || wordCount !== 9'd4) begin errors++; $display("[TB] FAIL t5_end: got err=%b done=%b wc=%0d expected 0 1 4", errOverflow, done, wordCount); end
    checks++; if (logN !== 4 || logAddr[3] !== 8'd3 || logData[3] !== 16'h0023) begin errors++; $display("[TB] FAIL t5_final: got n=%0d addr=%0d data=%h expected 4 3 0023", logN, logAddr[3], logData[3]); end
    checks++; if (checksum !== expSum(16'h0086)) begin errors++; $display("[TB] FAIL t5_sum: got %h expected %h", checksum, expSum(16'h0086)); end
  endtask

  task automatic test_back_to_back();
    logN = 0;
    pulseStart();
    checks++; if (cpuHold !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL t6_rehold: got hold=%b done=%b busy=%b expected 1 0 1", cpuHold, done, busy); end
    drive(1'b1, 16'hBEEF, 1'b1);
    idleCycles(2);
    checks++; if (logN !== 1 || logAddr[0] !== 8'd0 || logData[0] !== 16'hBEEF) begin errors++; $display("[TB] FAIL t6_write: got n=%0d addr=%0d data=%h expected 1 0 BEEF", logN, logAddr[0], logData[0]); end
    checks++; if (wordCount !== 9'd1 || cpuHold !== 1'b0 || done !== 1'b1) begin errors++; $display("[TB] FAIL t6_end: got wc=%0d hold=%b done=%b expected 1 0 1", wordCount, cpuHold, done); end
    checks++; if (checksum !== expSum(16'hBEEF)) begin errors++; $display("[TB] FAIL t6_sum: got %h expected %h", checksum, expSum(16'hBEEF)); end
  endtask

  initial begin
    rst            = 1'b0;
    start          = 1'b0;
    inBus.in_valid = 1'b0;
    inBus.in_data  = '0;
    inBus.in_last  = 1'b0;
    logN           = 0;
    tick();
    tick();
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_last_on_full();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
